// File: rtl/common.sv
// Shared instruction-bus request/response types, responder FSM states and stall-LFSR constants.
// Pure declarations: no latency, no flow control.
package common;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } ibus_state_e;

    // x^16+x^14+x^13+x^11+1 as a left-shifting Fibonacci register: taps on bits 15,13,12,10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/ibus_stall_lfsr.sv
// Free-running 16-bit LFSR that flags a one-cycle stall when its low two bits are zero.
// Latency: stall reflects the current register, advancing every cycle; no backpressure.
// Only built when IBUS_RESP_STALL_EN is defined.
`ifdef IBUS_RESP_STALL_EN
module ibus_stall_lfsr
    import common::*;
(
    input  logic clk,
    input  logic rst,
    output logic stall
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign stall = (lfsr_q[1:0] == 2'b00);

endmodule
`endif

// File: rtl/ibus_responder.sv
// Instruction-bus responder: one fetch at a time, word from internal array after LATENCY cycles.
// Latency: data_ok in the cycle after edge E+LATENCY; throughput one word per LATENCY+2 cycles.
// Backpressure: none; requester holds valid until data_ok, dropping it in WAIT aborts.
// IBUS_RESP_STALL_EN adds LFSR-driven random extra wait cycles.
module ibus_responder
    import common::*;
#(
    parameter int unsigned DEPTH   = 4096,
    parameter int unsigned LATENCY = 2,
    parameter logic [63:0] BASE    = 64'h8000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  ibus_req_t                ireq,
    output ibus_resp_t               iresp,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_idx,
    input  logic [31:0]              load_data,
    output logic                     busy
);

    localparam int unsigned IW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];

    ibus_state_e   state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [31:0]   data_q, data_d;
    logic          ok_q, ok_d;
    logic          stall;
    logic [63:0]   offs;
    logic          unused_offs;

    // Upper offset bits wrap modulo DEPTH; byte-lane bits are don't-care.
    assign offs        = ireq.addr - BASE;
    assign unused_offs = ^{offs[63:IW+2], offs[1:0]};

`ifdef IBUS_RESP_STALL_EN
    ibus_stall_lfsr u_stall (
        .clk   (clk),
        .rst   (rst),
        .stall (stall)
    );
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        ok_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ireq.valid) begin
                    state_d = S_WAIT;
                    idx_d   = offs[IW+1:2];
                    cnt_d   = 4'(LATENCY - 1);
                end
            end
            S_WAIT: begin
                if (!ireq.valid) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (!stall) begin
                    state_d = S_RESP;
                    ok_d    = 1'b1;
                    // A load landing on the read edge must be visible in the response.
                    data_d  = (load_en && (load_idx == idx_q)) ? load_data : mem[idx_q];
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                data_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                data_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            ok_q    <= ok_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_idx] <= load_data;
        end
    end

    assign iresp.addr_ok = ok_q;
    assign iresp.data_ok = ok_q;
    assign iresp.data    = data_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_ibus_responder.sv
// Scoreboard bench: two responders (LATENCY 2 and 1) sharing one load port; a monitor pops expectations on data_ok.
module tb_ibus_responder;
    import common::*;

    localparam int LAT0 = 2;
    localparam int LAT1 = 1;

    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    ibus_req_t   ireq [2];
    ibus_resp_t  iresp [2];
    logic        busy [2];
    logic        load_en;
    logic [11:0] load_idx;
    logic [31:0] load_data;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   last_ok [2] = '{-100, -100};
    exp_t q0 [$];
    exp_t q1 [$];
    int   lat_log [$];
    int   run1 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ibus_responder #(.DEPTH(4096), .LATENCY(LAT0), .BASE(64'h8000_0000)) dut_a (
        .clk(clk), .rst(rst), .ireq(ireq[0]), .iresp(iresp[0]),
        .load_en(load_en), .load_idx(load_idx), .load_data(load_data), .busy(busy[0])
    );

    ibus_responder #(.DEPTH(4096), .LATENCY(LAT1), .BASE(64'h8000_0000)) dut_b (
        .clk(clk), .rst(rst), .ireq(ireq[1]), .iresp(iresp[1]),
        .load_en(load_en), .load_idx(load_idx), .load_data(load_data), .busy(busy[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        bit   have;
        for (int k = 0; k < 2; k++) begin
            if (iresp[k].data_ok) begin
                have = 1'b0;
                if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                chk("expected_data_ok", 64'(have), 64'd1);
                if (have) begin
                    chk("resp_data", 64'(iresp[k].data), 64'(e.d));
                    chk("resp_addr_ok", 64'(iresp[k].addr_ok), 64'd1);
`ifdef IBUS_RESP_STALL_EN
                    chk("latency_min", 64'(cyc >= e.c), 64'd1);
                    if (k == 0) lat_log.push_back(cyc - e.c);
`else
                    chk("resp_cycle", 64'(cyc), 64'(e.c));
`endif
                end
                chk("single_pulse", 64'((cyc - last_ok[k]) > 1), 64'd1);
                last_ok[k] = cyc;
            end else begin
                chk("quiet_resp_zero", 64'(iresp[k]), 64'd0);
            end
        end
    end

    task automatic load(input logic [11:0] idx, input logic [31:0] dat);
        load_en   = 1'b1;
        load_idx  = idx;
        load_data = dat;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    // Called at a negedge; extra=1 when the DUT is currently in RESP, so acceptance slips one edge.
    task automatic issue(input int k, input logic [63:0] a, input logic [31:0] d, input bit extra);
        exp_t e;
        e.d = d;
        e.c = cyc + 1 + (extra ? 1 : 0) + ((k == 0) ? LAT0 : LAT1);
        if (k == 0) q0.push_back(e); else q1.push_back(e);
        ireq[k] = '{valid: 1'b1, addr: a};
    endtask

    task automatic wait_ok(input int k);
        int n = 0;
        while (!iresp[k].data_ok && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("data_ok_seen", 64'(iresp[k].data_ok), 64'd1);
    endtask

    task automatic idle(input int k);
        ireq[k].valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b0;
        load_en   = 1'b0;
        load_idx  = '0;
        load_data = '0;
        ireq[0]   = '0;
        ireq[1]   = '0;
        repeat (3) @(negedge clk);
        chk("reset_resp_a", 64'(iresp[0]), 64'd0);
        chk("reset_busy_a", 64'(busy[0]), 64'd0);
        chk("reset_busy_b", 64'(busy[1]), 64'd0);
        rst = 1'b1;

        load(12'd0, 32'h0000_0093);
        load(12'd1, 32'h1234_5678);
        load(12'd4095, 32'hDEAD_BEEF);
        for (int i = 2; i < 14; i++) load(12'(i), 32'hA5A5_0000 + 32'(i));

        // Basic fetch, wrap above and below BASE (byte-lane bits ignored)
        issue(0, 64'h8000_0000, 32'h0000_0093, 1'b0); wait_ok(0); idle(0);
        issue(0, 64'h8000_4004, 32'h1234_5678, 1'b0); wait_ok(0); idle(0);
        issue(1, 64'h7FFF_FFFE, 32'hDEAD_BEEF, 1'b0); wait_ok(1); idle(1);

        // Abort: valid drops one cycle after acceptance
        ireq[0] = '{valid: 1'b1, addr: 64'h8000_0008};
        @(negedge clk);
        chk("abort_busy_in_wait", 64'(busy[0]), 64'd1);
        ireq[0].valid = 1'b0;
        @(negedge clk);
        chk("abort_busy_dropped", 64'(busy[0]), 64'd0);
        repeat (4) @(negedge clk);
        issue(0, 64'h8000_0008, 32'hA5A5_0002, 1'b0); wait_ok(0); idle(0);

        // Reset for one edge mid-WAIT
        ireq[0] = '{valid: 1'b1, addr: 64'h8000_000C};
        @(negedge clk);
        rst = 1'b0;
        ireq[0].valid = 1'b0;
        @(negedge clk);
        chk("midrst_resp", 64'(iresp[0]), 64'd0);
        chk("midrst_busy", 64'(busy[0]), 64'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Load on the very edge the response word is read
        issue(0, 64'h8000_0014, 32'h5555_AAAA, 1'b0);
        @(negedge clk);
        @(negedge clk);
        load_en   = 1'b1;
        load_idx  = 12'd5;
        load_data = 32'h5555_AAAA;
        @(negedge clk);
        load_en   = 1'b0;
        wait_ok(0); idle(0);

        // Back-to-back, LATENCY=1: pulses 3 cycles apart
        for (int i = 0; i < 8; i++) begin
            issue(1, 64'h8000_0000 + 64'(4 * (i + 6)), 32'hA5A5_0000 + 32'(i + 6), i > 0);
            @(negedge clk);
            wait_ok(1);
        end
        idle(1);

`ifdef IBUS_RESP_STALL_EN
        for (int p = 0; p < 2; p++) begin
            rst = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            lat_log.delete();
            for (int i = 0; i < 50; i++) begin
                issue(0, 64'h8000_0000 + 64'(4 * (6 + i % 8)), 32'hA5A5_0000 + 32'(6 + i % 8), i > 0);
                @(negedge clk);
                wait_ok(0);
            end
            idle(0);
            if (p == 0) run1 = lat_log;
        end
        chk("stall_run_len", 64'(lat_log.size()), 64'(run1.size()));
        for (int i = 0; i < run1.size() && i < lat_log.size(); i++)
            chk("stall_run_repeat", 64'(lat_log[i]), 64'(run1[i]));
`endif

        repeat (5) @(negedge clk);
        chk("queue_a_drained", 64'(q0.size()), 64'd0);
        chk("queue_b_drained", 64'(q1.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
